// File: rtl/adder_pkg.sv
// Shared constants and types for the nibble-serial add/subtract engine.
package adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result handshake bundle for the nibble-serial adder controller.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
  );

endinterface

// File: rtl/adder_slice4.sv
// 4-bit ripple adder slice built from full_adder cells.
module adder_slice4
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract engine: one 4-bit slice is reused across operand nibbles,
// LSB first, with the carry held in a register between nibbles.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst,
  nibble_serial_adder_ctrl_if.slave bus
);

  localparam int unsigned NIBS = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] slice_a;
  logic [NIB_W-1:0] slice_b;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;

  assign slice_a = a_q[idx_q*NIB_W +: NIB_W];
  assign slice_b = b_q[idx_q*NIB_W +: NIB_W];

  adder_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state: accept in IDLE, step one nibble per RUN cycle, release in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          // Subtract as A + ~B + 1, the +1 entering through the initial carry.
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*NIB_W +: NIB_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          ovf_d   = (slice_a[NIB_W-1] == slice_b[NIB_W-1]) &&
                    (slice_sum[NIB_W-1] != slice_a[NIB_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake and result outputs; in_ready is held low while reset is applied.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_sum   = result_q;
    bus.out_carry = carry_q;
    bus.out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: the driver queues expected results, a negedge monitor
// pops and compares them on every output handshake.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    string            name;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got sum %0h with empty scoreboard", bus.out_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_sum"}, 32'(bus.out_sum), 32'(e.sum));
        chk({e.name, "_carry"}, 32'(bus.out_carry), 32'(e.carry));
        chk({e.name, "_ovf"}, 32'(bus.out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check its output latency and the return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic [WIDTH-1:0] es, input logic ec,
                        input logic eo, input string nm, input bit stall);
    int n;
    exp_t e;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk({nm, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    e.sum = es; e.carry = ec; e.ovf = eo; e.name = nm;
    exp_q.push_back(e);
    tick();
    // Operands after the accept edge must be ignored.
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hDEAD;
    bus.in_b     = 16'hBEEF;
    bus.in_sub   = ~sub;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd5);
    if (!stall) begin
      tick();
      chk({nm, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_sum", 32'(bus.out_sum), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic", 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry_chain", 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf", 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow", 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf", 1'b0);

    // Output stall with a request queued behind it.
    bus.out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, "stall", 1'b1);
    begin
      exp_t e;
      e.sum = 16'h0002; e.carry = 1'b0; e.ovf = 1'b0; e.name = "queued";
      exp_q.push_back(e);
    end
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h0001;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_sum", 32'(bus.out_sum), 32'h3333);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("post_stall_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("queued_accepted_busy", 32'(bus.busy), 32'd1);
    begin
      int n;
      n = 1;
      while (!bus.out_valid && n < 20) begin
        tick();
        n++;
      end
      chk("queued_latency", 32'(n), 32'd5);
    end
    tick();

    // Reset during the second RUN cycle aborts without output.
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'h0001;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sum", 32'(bus.out_sum), 32'd0);
    chk("abort_carry", 32'(bus.out_carry), 32'd0);
    chk("abort_ovf", 32'(bus.out_ovf), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(bus.in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.out_valid) seen = 1;
      end
      chk("abort_no_output", 32'(seen), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset_add", 1'b0);

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs WIDTH-bit add/subtract operations by time-multiplexing one 4-bit adder slice over the operand nibbles, LSB first, with a registered carry between nibbles. It accepts operations over a valid/ready input port and returns sum, carry and signed overflow over a valid/ready output port. It trades latency for area against a full-width ripple adder and is the standard wide-add engine for the datapath.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  controller can accept an operation.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_carry  output  1  final carry out; for subtract, 1 = no borrow.
- out_ovf  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- NIBS = WIDTH/4. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block registers A, B' = in_sub ? ~in_b : in_b, carry = in_sub, and idx = 0, then goes to RUN.
- RUN: the slice adds A[idx], B'[idx] and carry. The sum nibble is written to result[idx], carry takes the slice carry out, and idx increments. When idx = NIBS-1, the block goes to DONE.
- In the last nibble, ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), registered.
- DONE: out_valid=1. out_sum, out_carry and out_ovf are held stable until out_ready. On out_valid&&out_ready, the block returns to IDLE.
- in_ready=0 in RUN and DONE. No new operation is accepted until the previous result handshakes.
- out_sum, out_carry and out_ovf are meaningful only while out_valid=1. The result register is overwritten during RUN.
- Input operands are sampled only on the accept edge. Later changes on in_a, in_b and in_sub have no effect.

## Timing
- Cycle 0 is the handshake cycle (IDLE). Cycles 1..NIBS are RUN, with nibble k-1 processed in cycle k. out_valid rises in cycle NIBS+1 (5 for WIDTH=16).
- With out_ready=1 in the first DONE cycle, IDLE and in_ready=1 follow in cycle NIBS+2. Minimum spacing between accepts is NIBS+2 cycles.
- out_ready low stalls indefinitely in DONE. There is no timeout.
- rst=1 on any edge forces IDLE, clears idx, carry, ovf and result to 0, and drives out_valid=0 and busy=0.
- in_ready=0 while rst=1 and becomes 1 in the first cycle after rst deasserts.
- Reset mid-RUN or mid-DONE aborts the operation with no output.

## Structure
- Shared package adder_pkg holds NIB_W=4 and the state enum typedef (IDLE, RUN, DONE).
- Sub-module adder_slice4 is a 4-bit ripple adder with cin, sum and cout, built from the existing full_adder cell. It is instantiated once; all nibble multiplexing and carry registration live in the controller.

## Test plan
- WIDTH=16, 0x1234+0x4321 -> out_sum=0x5555, carry=0, ovf=0; out_valid high exactly 5 cycles after the accept cycle.
- 0xFFFF+0x0001 -> out_sum=0x0000, carry=1, ovf=0; exercises the carry chain across all 4 nibbles.
- 0x7FFF+0x0001 -> out_sum=0x8000, carry=0, ovf=1.
- Subtract 0x0005-0x0007 -> 0xFFFE, carry=0, ovf=0. Subtract 0x8000-0x0001 -> 0x7FFF, carry=1, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and data stay stable, and in_ready=0 with in_valid held high. Then assert out_ready -> IDLE and in_ready=1 the next cycle, and a queued request is accepted.
- Assert rst during the second RUN cycle of 0xFFFF+0x0001 -> out_valid never rises and outputs read 0. A new 0x0001+0x0001 after reset -> 0x0002 with no stale carry.
